// File: rtl/sprite_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_arbiter
// Purpose  : Per-pixel priority arbiter that shares one sprite ROM across
//            N_SPRITES on-screen objects, with shadowed per-frame positions.
// Revision : 1.0  initial release
// ============================================================================
module sprite_arbiter #(
    parameter int             N_SPRITES  = 4,
    parameter int             SPR_W      = 50,
    parameter int             SPR_H      = 40,
    parameter int             ADDR_W     = 13,
    parameter logic [7:0]     TRANSP_IDX = 8'h00,
    localparam int            SLOT_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
    input  logic                          vga_clk,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic [N_SPRITES-1:0]          obj_valid,
    input  logic [10*N_SPRITES-1:0]       obj_x,
    input  logic [10*N_SPRITES-1:0]       obj_y,
    input  logic [ADDR_W*N_SPRITES-1:0]   obj_base,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          blank,
    output logic [ADDR_W-1:0]             rom_address,
    input  logic [7:0]                    rom_q,
    output logic [7:0]                    pix_index,
    output logic                          pix_valid,
    output logic [SLOT_W-1:0]             pix_slot,
    output logic [7:0]                    overlap_cnt
);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           w_active;

    logic [N_SPRITES-1:0]           r_sv;
    logic [10*N_SPRITES-1:0]        r_sx;
    logic [10*N_SPRITES-1:0]        r_sy;
    logic [ADDR_W*N_SPRITES-1:0]    r_sbase;

    logic [N_SPRITES-1:0]           w_hit;
    logic                           w_hit_any;
    logic                           w_multi;
    logic [SLOT_W-1:0]              w_win;
    logic [9:0]                     w_wx;
    logic [9:0]                     w_wy;
    logic [ADDR_W-1:0]              w_wbase;
    logic [10:0]                    w_offx;
    logic [10:0]                    w_offy;
    logic [ADDR_W-1:0]              w_addr;

    logic                           r_hit;
    logic [SLOT_W-1:0]              r_slot;
    logic [7:0]                     r_ovl_cnt;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_FRAME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        case (r_state)
            WAIT_FRAME: begin
                if (frame_start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_active = 1'b1;
            end
            default: begin
                w_state_nxt = WAIT_FRAME;
            end
        endcase
    end

    // Shadows are the only copy the pixel path sees, so game logic can write
    // obj_* at any time without tearing the current frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sv    <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_sbase <= '0;
        end else if (frame_start) begin
            r_sv    <= obj_valid;
            r_sx    <= obj_x;
            r_sy    <= obj_y;
            r_sbase <= obj_base;
        end
    end

    // 11-bit compares keep x+SPR_W from wrapping past the screen edge.
    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_hit
        logic [10:0] w_x0;
        logic [10:0] w_y0;
        logic [10:0] w_px;
        logic [10:0] w_py;
        assign w_x0 = {1'b0, r_sx[10*gi +: 10]};
        assign w_y0 = {1'b0, r_sy[10*gi +: 10]};
        assign w_px = {1'b0, DrawX};
        assign w_py = {1'b0, DrawY};
        assign w_hit[gi] = w_active && r_sv[gi] && blank &&
                           (w_px >= w_x0) && (w_px < w_x0 + 11'(SPR_W)) &&
                           (w_py >= w_y0) && (w_py < w_y0 + 11'(SPR_H));
    end

    always_comb begin
        w_win = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win = SLOT_W'(i);
            end
        end
    end

    assign w_hit_any = |w_hit;
    assign w_multi   = (w_hit & (w_hit - 1'b1)) != '0;

    assign w_wx    = r_sx[10*w_win +: 10];
    assign w_wy    = r_sy[10*w_win +: 10];
    assign w_wbase = r_sbase[ADDR_W*w_win +: ADDR_W];
    assign w_offx  = {1'b0, DrawX} - {1'b0, w_wx};
    assign w_offy  = {1'b0, DrawY} - {1'b0, w_wy};
    assign w_addr  = w_wbase + ADDR_W'(w_offy * SPR_W) + ADDR_W'(w_offx);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            r_hit       <= 1'b0;
            r_slot      <= '0;
            pix_index   <= 8'h00;
            pix_valid   <= 1'b0;
            pix_slot    <= '0;
        end else begin
            r_hit  <= w_hit_any;
            r_slot <= w_hit_any ? w_win : '0;
            if (w_hit_any) begin
                rom_address <= w_addr;
            end
            pix_index <= r_hit ? rom_q : 8'h00;
            pix_valid <= r_hit && (rom_q != TRANSP_IDX);
            pix_slot  <= r_hit ? r_slot : '0;
        end
    end

    // An overlap seen in the frame_start cycle seeds the new frame's count.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovl_cnt   <= 8'h00;
            overlap_cnt <= 8'h00;
        end else if (frame_start) begin
            overlap_cnt <= r_ovl_cnt;
            r_ovl_cnt   <= w_multi ? 8'h01 : 8'h00;
        end else if (w_multi && (r_ovl_cnt != 8'hFF)) begin
            r_ovl_cnt <= r_ovl_cnt + 8'h01;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_arbiter
// Purpose  : Directed self-checking bench for sprite_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_arbiter;

    localparam int N      = 4;
    localparam int ADDR_W = 13;

    logic                 clk;
    logic                 rst_n;
    logic                 frame_start;
    logic [N-1:0]         obj_valid;
    logic [10*N-1:0]      obj_x;
    logic [10*N-1:0]      obj_y;
    logic [ADDR_W*N-1:0]  obj_base;
    logic [9:0]           DrawX;
    logic [9:0]           DrawY;
    logic                 blank;
    logic [ADDR_W-1:0]    rom_address;
    logic [7:0]           rom_q;
    logic [7:0]           pix_index;
    logic                 pix_valid;
    logic [1:0]           pix_slot;
    logic [7:0]           overlap_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sprite_arbiter #(
        .N_SPRITES (N),
        .SPR_W     (50),
        .SPR_H     (40),
        .ADDR_W    (ADDR_W),
        .TRANSP_IDX(8'h00)
    ) u_dut (
        .vga_clk    (clk),
        .reset_n    (rst_n),
        .frame_start(frame_start),
        .obj_valid  (obj_valid),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_base   (obj_base),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .pix_index  (pix_index),
        .pix_valid  (pix_valid),
        .pix_slot   (pix_slot),
        .overlap_cnt(overlap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_obj(input int s, input logic v, input logic [9:0] x,
                           input logic [9:0] y, input logic [ADDR_W-1:0] b);
        obj_valid[s]              = v;
        obj_x[10*s +: 10]         = x;
        obj_y[10*s +: 10]         = y;
        obj_base[ADDR_W*s +: ADDR_W] = b;
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // One pixel through the pipeline: address at t+1, pixel result at t+2.
    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] q, input logic exp_hit,
                       input logic [ADDR_W-1:0] exp_addr, input logic [1:0] exp_slot);
        @(posedge clk); #1;
        DrawX = x;
        DrawY = y;
        blank = 1'b1;
        @(posedge clk); #1;
        blank = 1'b0;
        rom_q = q;
        chk({tag, "_addr"}, 32'(rom_address), 32'(exp_addr));
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(pix_valid), 32'(exp_hit && (q != 8'h00)));
        chk({tag, "_index"}, 32'(pix_index), exp_hit ? 32'(q) : 32'h0);
        chk({tag, "_slot"},  32'(pix_slot),  exp_hit ? 32'(exp_slot) : 32'h0);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                DrawX = 10'(xx);
                DrawY = 10'(yy);
                blank = 1'b1;
                @(posedge clk); #1;
            end
        end
        blank = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        obj_valid   = '1;
        obj_x       = '0;
        obj_y       = '0;
        obj_base    = '0;
        DrawX       = 10'd10;
        DrawY       = 10'd10;
        blank       = 1'b1;
        rom_q       = 8'h55;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'({rom_address, pix_index, pix_valid, pix_slot, overlap_cnt}), 32'h0);
        rst_n = 1'b1;

        // No frame_start yet: nothing may be rendered.
        for (int k = 0; k < 100; k++) begin
            DrawX = 10'($urandom_range(0, 60));
            DrawY = 10'($urandom_range(0, 50));
            rom_q = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            chk("wait_frame_outs",
                32'({rom_address, pix_index, pix_valid, pix_slot, overlap_cnt}), 32'h0);
        end
        blank = 1'b0;

        obj_valid = '0;
        obj_x     = '0;
        obj_y     = '0;
        obj_base  = '0;
        set_obj(0, 1'b1, 10'd100, 10'd50, 13'd0);
        pulse_frame();
        pix("single", 10'd102, 10'd53, 8'h07, 1'b1, 13'd152, 2'd0);

        // Mid-frame object move is invisible until the next frame_start.
        set_obj(0, 1'b1, 10'd300, 10'd50, 13'd0);
        pix("shadow_old", 10'd102, 10'd53, 8'h09, 1'b1, 13'd152, 2'd0);
        pulse_frame();
        pix("shadow_gone", 10'd102, 10'd53, 8'h09, 1'b0, 13'd152, 2'd0);
        pix("shadow_new", 10'd303, 10'd54, 8'h0A, 1'b1, 13'd203, 2'd0);

        // Async reset mid-frame drops back to waiting for a frame.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_addr", 32'(rom_address), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix("after_reset", 10'd303, 10'd54, 8'h0A, 1'b0, 13'd0, 2'd0);

        obj_valid = '0;
        set_obj(0, 1'b1, 10'd190, 10'd190, 13'd0);
        set_obj(2, 1'b1, 10'd180, 10'd185, 13'd4000);
        pulse_frame();
        pix("prio_s0", 10'd200, 10'd200, 8'h11, 1'b1, 13'd510, 2'd0);
        pix("transp", 10'd200, 10'd200, 8'h00, 1'b1, 13'd510, 2'd0);
        set_obj(0, 1'b0, 10'd190, 10'd190, 13'd0);
        pulse_frame();
        pix("prio_s2", 10'd200, 10'd200, 8'h22, 1'b1, 13'd4770, 2'd2);

        obj_valid = '0;
        set_obj(1, 1'b1, 10'd620, 10'd100, 13'd0);
        set_obj(3, 1'b1, 10'd1000, 10'd100, 13'd0);
        pulse_frame();
        pix("edge_hit", 10'd639, 10'd100, 8'h21, 1'b1, 13'd19, 2'd1);
        pix("edge_nowrap", 10'd5, 10'd100, 8'h33, 1'b0, 13'd19, 2'd0);

        // 10x10 overlap region: x 140..149, y 130..139.
        obj_valid = '0;
        set_obj(0, 1'b1, 10'd100, 10'd100, 13'd0);
        set_obj(1, 1'b1, 10'd140, 10'd130, 13'd2000);
        pulse_frame();
        scan(130, 159, 120, 149);
        set_obj(1, 1'b1, 10'd100, 10'd100, 13'd2000);
        pulse_frame();
        chk("ovl_100", 32'(overlap_cnt), 32'd100);

        scan(100, 149, 100, 105);
        @(posedge clk); #1;
        DrawX       = 10'd100;
        DrawY       = 10'd100;
        blank       = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        blank       = 1'b0;
        chk("ovl_sat", 32'(overlap_cnt), 32'd255);
        pulse_frame();
        chk("ovl_fs_cycle", 32'(overlap_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_arbiter.md
Name: sprite_arbiter

Overview:
- Shares one sprite ROM (palette-indexed, 1-cycle read latency) among N_SPRITES on-screen fruit objects.
- Each pixel: finds the highest-priority object covering (DrawX, DrawY), forms its ROM address, and returns the palette index with a valid flag to the colour mapper.
- Object positions and image bases are snapshotted at frame start, so the game FSM can update them at any time without tearing.
- Sits between the game-logic object registers and the shared sprite ROM/palette.

Parameters:
- N_SPRITES, 4, number of object slots; slot 0 has highest priority.
- SPR_W, 50, sprite width in pixels.
- SPR_H, 40, sprite height in pixels.
- ADDR_W, 13, ROM address width (holds several SPR_W*SPR_H images).
- TRANSP_IDX, 8'h00, palette index treated as transparent.

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- obj_valid  in  N_SPRITES  per-slot enable.
- obj_x  in  10*N_SPRITES  per-slot top-left X, slot i at bits [10i+9:10i].
- obj_y  in  10*N_SPRITES  per-slot top-left Y, same packing.
- obj_base  in  ADDR_W*N_SPRITES  per-slot image base address in the ROM.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- blank  in  1  1 = active video.
- rom_address  out  ADDR_W  registered ROM address.
- rom_q  in  8  ROM data; valid one vga_clk after rom_address changes.
- pix_index  out  8  palette index of the winning sprite pixel.
- pix_valid  out  1  1 = sprite pixel opaque (draw pix_index); 0 = background.
- pix_slot  out  $clog2(N_SPRITES)  winning slot number (for slice hit detection).
- overlap_cnt  out  8  count of overlapping-object pixels in the last completed frame.

Behaviour:
- Reset (async, reset_n=0) sets the following to 0: shadow_valid, all shadow registers, rom_address, pix_index, pix_valid, pix_slot, overlap_cnt, and internal pipeline registers. FSM enters WAIT_FRAME.
- FSM:
  - WAIT_FRAME: outputs held at 0 and no ROM addressing. On frame_start, load shadows and go to RUN.
  - RUN: on each frame_start, reload shadows. The new shadows are used from the next cycle.
  - Deasserting reset_n mid-frame returns to WAIT_FRAME; no pixel output until the next frame_start.
- Shadow load copies obj_valid, obj_x, obj_y, and obj_base for all slots in one cycle. Input changes at other times are ignored.
- Hit test per slot i (all arithmetic 11-bit unsigned, so no wrap at screen edge):
  - hit_i = sv_i && blank && DrawX >= x_i && DrawX < x_i+SPR_W && DrawY >= y_i && DrawY < y_i+SPR_H.
  - Sprites partly off the right/bottom edge are clipped, never wrapped.
- Arbitration: the lowest-index slot with hit wins. Only the winner's ROM word is fetched. If the winner's texel is transparent, the result is background; lower slots are not consulted.
- Address: rom_address = base_w + (DrawY-y_w)*SPR_W + (DrawX-x_w), truncated to ADDR_W.
- Pipeline, total latency 2 cycles from DrawX/DrawY to pix_*:
  - Cycle t: DrawX/DrawY sampled.
  - t+1: rom_address, hit_any, and winning slot registered.
  - t+2: pix_index = rom_q, pix_valid = hit_any && rom_q != TRANSP_IDX, pix_slot = winning slot.
  - When there is no hit: rom_address holds its previous value, pix_valid=0, pix_index=0, pix_slot=0.
- Overlap counting:
  - An internal counter increments (saturating at 255) on each cycle where two or more slots hit.
  - On frame_start, the counter is copied to overlap_cnt and cleared.
  - A simultaneous overlap in the frame_start cycle counts toward the new frame.
- frame_start coinciding with active pixels: the shadow update takes effect next cycle. A pixel already in the pipeline completes with the old values.

Test Plan:
- Reset: hold reset_n=0, then release with no frame_start → all outputs 0 for 100 cycles regardless of DrawX/DrawY.
- Single sprite: slot0 valid, x=100, y=50, base=0; frame_start, then DrawX=102, DrawY=53 → rom_address=152 at t+1; rom_q=8'h07 → pix_valid=1, pix_index=07, pix_slot=0 at t+2.
- Priority: slots 0 and 2 both cover (200,200) with bases 0 and 4000 → rom_address uses base 0, pix_slot=0. Same pixel with slot 0 invalid → base 4000 used, pix_slot=2.
- Transparency and edge clipping:
  - Slot0 texel returns TRANSP_IDX → pix_valid=0.
  - Slot at x=620, DrawX=639 → hit.
  - DrawX=5 on the same row → no hit (no wrap).
- Shadow timing: change obj_x mid-frame → rendering unchanged until after the next frame_start pulse.
- Overlap: two sprites overlapping over a 10x10 area for one frame → after the next frame_start, overlap_cnt=100. Overlap of 300 pixels → overlap_cnt=255.
